pixel_word_packer: RTL and testbench

- Sits directly downstream of the video input port stage: consumes its pixel stream (odata_vld/odata) and the frame/line/end alignment strobes.
- Packs pixels into memory-width words and writes them into the VDMA write-side FIFO.
- Flushes partial words on line or frame boundaries according to MODE.
- Tags each word with frame-first, line-last and frame-last flags, and reports FIFO overflow.

---
 rtl/vdma_pkg.sv | 9 +
 rtl/pack_lane_insert.sv | 15 +
 rtl/pixel_word_packer.sv | 73 +++++++
 tb/tb_pixel_word_packer.sv | 132 +++++++++++++
 4 files changed

// File: rtl/vdma_pkg.sv
// vdma_pkg: VDMA write-path constants, lane-count derivation and an elaboration-time parameter check macro
`define VDMA_WIDTH_CHECK(name, cond, msg) if (!(cond)) begin : name $error(msg); end
package vdma_pkg;
  localparam logic [31:0] MODE_LINE = "LINE";
  localparam logic [31:0] MODE_ONCE = "ONCE";
  function automatic int nlane(input int msize, input int lsize);
    return msize / lsize;
  endfunction
endpackage

// File: rtl/pack_lane_insert.sv
// pack_lane_insert: acc_out = acc with pixel pix zero-extended into lane index lane (lanes above lane must be empty in acc)
module pack_lane_insert import vdma_pkg::*; #(
  parameter int DSIZE = 24,
  parameter int LSIZE = 32,
  parameter int MSIZE = 128,
  parameter int LW = 2
)(
  input  logic [MSIZE-1:0] acc,
  input  logic [LW-1:0]    lane,
  input  logic [DSIZE-1:0] pix,
  output logic [MSIZE-1:0] acc_out
);
  `VDMA_WIDTH_CHECK(g_msize_chk, nlane(MSIZE, LSIZE) * LSIZE == MSIZE, "pack_lane_insert: MSIZE must be a multiple of LSIZE")
  always_comb acc_out = acc | (MSIZE'(pix) << (int'(lane) * LSIZE));
endmodule

// File: rtl/pixel_word_packer.sv
// pixel_word_packer: packs pixels (clock/rst, falign/lalign/ealign strobes, idata_vld/idata) into MSIZE words on the FIFO write side (fifo_*), with word_cnt and sticky overflow/clr_overflow
module pixel_word_packer import vdma_pkg::*; #(
  parameter int DSIZE = 24,
  parameter int LSIZE = 32,
  parameter int MSIZE = 128,
  parameter logic [31:0] MODE = MODE_LINE
)(
  input  logic             clock,
  input  logic             rst,
  input  logic             falign,
  input  logic             lalign,
  input  logic             ealign,
  input  logic             idata_vld,
  input  logic [DSIZE-1:0] idata,
  input  logic             fifo_full,
  output logic             fifo_wr_en,
  output logic [MSIZE-1:0] fifo_wdata,
  output logic             fifo_wfirst,
  output logic             fifo_wlinelast,
  output logic             fifo_wlast,
  output logic [31:0]      word_cnt,
  output logic             overflow,
  input  logic             clr_overflow
);
  localparam int NLANE = nlane(MSIZE, LSIZE);
  localparam int LW = NLANE > 1 ? $clog2(NLANE) : 1;
  `VDMA_WIDTH_CHECK(g_dsize_chk, DSIZE <= LSIZE, "pixel_word_packer: DSIZE exceeds LSIZE")
  `VDMA_WIDTH_CHECK(g_mode_chk, MODE == MODE_LINE || MODE == MODE_ONCE, "pixel_word_packer: MODE must be LINE or ONCE")
  logic [LW-1:0] lane, lane_b;
  logic [MSIZE-1:0] acc, acc_b, acc_n;
  logic pend_first, line_seen, first_b, line_b, filled, complete, wr;
  always_comb begin
    lane_b = falign ? '0 : lane;
    acc_b = falign ? '0 : acc;
    first_b = falign || pend_first;
    line_b = !falign && line_seen;
    filled = idata_vld || lane_b != '0;
    complete = (idata_vld && lane_b == LW'(NLANE - 1)) || (filled && (ealign || (lalign && MODE == MODE_LINE)));
    wr = complete && !fifo_full;
  end
  pack_lane_insert #(.DSIZE(DSIZE), .LSIZE(LSIZE), .MSIZE(MSIZE), .LW(LW)) u_insert (
    .acc(acc_b), .lane(lane_b), .pix(idata), .acc_out(acc_n)
  );
  always_ff @(posedge clock or posedge rst)
    if (rst) begin
      lane <= '0;
      acc <= '0;
      pend_first <= 1'b1;
      line_seen <= 1'b0;
      fifo_wr_en <= 1'b0;
      fifo_wdata <= '0;
      fifo_wfirst <= 1'b0;
      fifo_wlinelast <= 1'b0;
      fifo_wlast <= 1'b0;
      word_cnt <= '0;
      overflow <= 1'b0;
    end else begin
      lane <= complete ? '0 : lane_b + LW'(idata_vld);
      acc <= complete ? '0 : idata_vld ? acc_n : acc_b;
      pend_first <= first_b && !wr;
      line_seen <= !complete && (line_b || (lalign && filled));
      fifo_wr_en <= wr;
      if (wr) begin
        fifo_wdata <= idata_vld ? acc_n : acc_b;
        fifo_wfirst <= first_b;
        fifo_wlinelast <= line_b || lalign;
        fifo_wlast <= ealign;
      end else if (ealign && !filled && fifo_wr_en)
        fifo_wlast <= 1'b1;
      word_cnt <= falign ? 32'(wr) : word_cnt + 32'(wr && word_cnt != '1);
      overflow <= (complete && fifo_full) || (overflow && !clr_overflow);
    end
endmodule

// File: tb/tb_pixel_word_packer.sv
// tb_pixel_word_packer: scoreboard bench driving a LINE-mode and a ONCE-mode packer with directed pixel vectors
module tb_pixel_word_packer;
  typedef struct packed {
    logic [127:0] d;
    logic f, l, e;
    logic [31:0] c;
  } word_t;
  logic clk = 0, rst = 1, falign = 0, lalign = 0, ealign = 0, vld = 0, full = 0, clr = 0, sel_once = 0;
  logic [23:0] pix = 0;
  int checks = 0, errors = 0;
  word_t q_line[$], q_once[$];
  logic l_fa, l_la, l_ea, l_vld, l_full, l_clr, o_fa, o_la, o_ea, o_vld, o_full, o_clr;
  logic l_wr, l_wf, l_wl, l_we, l_ovf, o_wr, o_wf, o_wl, o_we, o_ovf;
  logic [127:0] l_wd, o_wd;
  logic [31:0] l_cnt, o_cnt;
  assign {l_fa, l_la, l_ea, l_vld, l_full, l_clr} = sel_once ? 6'b0 : {falign, lalign, ealign, vld, full, clr};
  assign {o_fa, o_la, o_ea, o_vld, o_full, o_clr} = sel_once ? {falign, lalign, ealign, vld, full, clr} : 6'b0;
  always #5 clk = ~clk;
  pixel_word_packer #(.DSIZE(24), .LSIZE(32), .MSIZE(128), .MODE("LINE")) u_line (
    .clock(clk), .rst(rst), .falign(l_fa), .lalign(l_la), .ealign(l_ea), .idata_vld(l_vld), .idata(pix),
    .fifo_full(l_full), .fifo_wr_en(l_wr), .fifo_wdata(l_wd), .fifo_wfirst(l_wf), .fifo_wlinelast(l_wl),
    .fifo_wlast(l_we), .word_cnt(l_cnt), .overflow(l_ovf), .clr_overflow(l_clr)
  );
  pixel_word_packer #(.DSIZE(24), .LSIZE(32), .MSIZE(128), .MODE("ONCE")) u_once (
    .clock(clk), .rst(rst), .falign(o_fa), .lalign(o_la), .ealign(o_ea), .idata_vld(o_vld), .idata(pix),
    .fifo_full(o_full), .fifo_wr_en(o_wr), .fifo_wdata(o_wd), .fifo_wfirst(o_wf), .fifo_wlinelast(o_wl),
    .fifo_wlast(o_we), .word_cnt(o_cnt), .overflow(o_ovf), .clr_overflow(o_clr)
  );
  function automatic void chk(input string name, input logic [199:0] got, input logic [199:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, got, exp);
    end
  endfunction
  function automatic word_t w(input logic [31:0] p3, p2, p1, p0, input logic f, l, e, input logic [31:0] c);
    return {p3, p2, p1, p0, f, l, e, c};
  endfunction
  task automatic step(input logic v, input logic [23:0] d, input logic f, input logic l, input logic e);
    vld = v;
    pix = d;
    falign = f;
    lalign = l;
    ealign = e;
    @(posedge clk);
    #1;
    {vld, falign, lalign, ealign} = 4'b0;
  endtask
  always @(negedge clk)
    if (l_wr) begin
      if (q_line.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL line_unexpected_write: got data %h, expected no write", l_wd);
      end else chk("line_word", {l_wd, l_wf, l_wl, l_we, l_cnt}, q_line.pop_front());
    end
  always @(negedge clk)
    if (o_wr) begin
      if (q_once.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL once_unexpected_write: got data %h, expected no write", o_wd);
      end else chk("once_word", {o_wd, o_wf, o_wl, o_we, o_cnt}, q_once.pop_front());
    end
  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("line_reset_outputs", {l_wr, l_wd, l_wf, l_wl, l_we, l_cnt, l_ovf}, '0);
    chk("once_reset_outputs", {o_wr, o_wd, o_wf, o_wl, o_we, o_cnt, o_ovf}, '0);
    rst = 0;
    @(posedge clk);
    #1;
    q_line.push_back(w(4, 3, 2, 1, 1, 0, 0, 1));
    step(1, 'h1, 1, 0, 0);
    for (int i = 2; i <= 4; i++) step(1, 24'(i), 0, 0, 0);
    q_line.push_back(w('h14, 'h13, 'h12, 'h11, 0, 0, 0, 2));
    q_line.push_back(w(0, 0, 'h16, 'h15, 0, 1, 0, 3));
    for (int i = 'h11; i <= 'h15; i++) step(1, 24'(i), 0, 0, 0);
    step(1, 'h16, 0, 1, 0);
    q_line.push_back(w('h24, 'h23, 'h22, 'h21, 1, 0, 0, 1));
    step(1, 'h21, 1, 0, 0);
    for (int i = 'h22; i <= 'h27; i++) step(1, 24'(i), 0, 0, 0);
    full = 1;
    step(1, 'h28, 0, 0, 0);
    full = 0;
    chk("ovf_set_on_drop", 200'(l_ovf), 200'(1));
    chk("cnt_held_on_drop", 200'(l_cnt), 200'(1));
    for (int i = 'h29; i <= 'h2b; i++) step(1, 24'(i), 0, 0, 0);
    full = 1;
    clr = 1;
    step(1, 'h2c, 0, 0, 0);
    {full, clr} = 2'b0;
    chk("ovf_set_wins_over_clr", 200'(l_ovf), 200'(1));
    clr = 1;
    step(0, 0, 0, 0, 0);
    clr = 0;
    chk("ovf_cleared", 200'(l_ovf), 200'(0));
    q_line.push_back(w('h34, 'h33, 'h32, 'h31, 0, 0, 0, 2));
    for (int i = 'h31; i <= 'h34; i++) step(1, 24'(i), 0, 0, 0);
    step(1, 'h41, 1, 0, 0);
    step(1, 'h42, 0, 0, 0);
    q_line.push_back(w('h54, 'h53, 'h52, 'h51, 1, 0, 0, 1));
    step(1, 'h51, 1, 0, 0);
    for (int i = 'h52; i <= 'h54; i++) step(1, 24'(i), 0, 0, 0);
    q_line.push_back(w(0, 0, 'h62, 'h61, 0, 1, 0, 2));
    step(1, 'h61, 0, 0, 0);
    step(1, 'h62, 0, 0, 0);
    step(0, 0, 0, 1, 0);
    step(0, 0, 0, 1, 0);
    step(1, 'h71, 0, 0, 0);
    step(1, 'h72, 0, 0, 0);
    #2 rst = 1;
    #1 chk("line_async_reset", {l_wr, l_wd, l_wf, l_wl, l_we, l_cnt, l_ovf}, '0);
    repeat (2) @(posedge clk);
    #1 rst = 0;
    q_line.push_back(w('h84, 'h83, 'h82, 'h81, 1, 0, 0, 1));
    for (int i = 'h81; i <= 'h84; i++) step(1, 24'(i), 0, 0, 0);
    step(0, 0, 0, 0, 0);
    sel_once = 1;
    q_once.push_back(w(4, 3, 2, 1, 1, 0, 0, 1));
    q_once.push_back(w(8, 7, 6, 5, 0, 1, 0, 2));
    q_once.push_back(w('hc, 'hb, 'ha, 9, 0, 1, 1, 3));
    step(1, 1, 1, 0, 0);
    for (int i = 2; i <= 11; i++) step(1, 24'(i), 0, i == 6, 0);
    step(1, 'hc, 0, 1, 1);
    repeat (4) step(0, 0, 0, 0, 0);
    chk("line_queue_drained", 200'(q_line.size()), 200'(0));
    chk("once_queue_drained", 200'(q_once.size()), 200'(0));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
